// File: rtl/poly_addsub_ctrl.sv
// Streaming coefficient-wise add / modular add / modular sub controller.
// Reads A[k], B[k] from two RAMs, writes the result to a third RAM two cycles later.
module poly_addsub_ctrl #(
   parameter int unsigned N      = 256,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned Q      = 8380417
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       a_rdata,
   input  logic [31:0]       b_rdata,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam logic [ADDR_W:0]   CntLast  = (ADDR_W + 1)'(N);
   localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(N - 1);
   localparam logic [32:0]       QExt     = 33'(Q);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

   logic              s1_valid_q;
   logic [ADDR_W-1:0] s1_addr_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [31:0]       wr_data_q;

   logic [32:0]       sum_ext, diff_ext, sum_red, diff_red;
   logic [31:0]       result;

   // Control: state, read counter, latched op and read-port registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= 2'b00;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               op_d      = op;
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               cnt_d     = (ADDR_W + 1)'(1);
            end
         end
         StRun: begin
            // cnt_q holds the next index to issue; reaching N means all reads are out
            if (cnt_q == CntLast) begin
               state_d = StDrain;
            end else begin
               rd_en_d   = 1'b1;
               rd_addr_d = cnt_q[ADDR_W-1:0];
               cnt_d     = cnt_q + 1'b1;
            end
         end
         StDrain: begin
            if (wr_en_q && (wr_addr_q == AddrLast)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Datapath arithmetic on the RAM outputs (valid while s1_valid_q is high)
   always_comb begin
      sum_ext  = {1'b0, a_rdata} + {1'b0, b_rdata};
      diff_ext = {1'b0, a_rdata} - {1'b0, b_rdata};
      sum_red  = (sum_ext >= QExt) ? (sum_ext - QExt) : sum_ext;
      diff_red = diff_ext[32] ? (diff_ext + QExt) : diff_ext;
      case (op_q)
         2'b00:   result = sum_ext[31:0];
         2'b01:   result = sum_red[31:0];
         default: result = diff_red[31:0];
      endcase
   end

   // Stage 1 tracks the outstanding read, stage 2 drives the result RAM
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         s1_valid_q <= rd_en_q;
         if (rd_en_q) begin
            s1_addr_q <= rd_addr_q;
         end
         wr_en_q <= s1_valid_q;
         if (s1_valid_q) begin
            wr_addr_q <= s1_addr_q;
            wr_data_q <= result;
         end
      end
   end

   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);
   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_poly_addsub_ctrl.sv
// Directed bench for poly_addsub_ctrl: table-driven arithmetic runs plus
// handshake, back-to-back, op-latch and mid-run reset sequences.
module tb_poly_addsub_ctrl;

   localparam int unsigned N      = 256;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned Q      = 8380417;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        op;
   logic              busy, done, rd_en, wr_en;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [31:0]       a_rdata, b_rdata, wr_data;

   always #5 clk = ~clk;

   poly_addsub_ctrl #(.N(N), .ADDR_W(ADDR_W), .Q(Q)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .busy    (busy),
      .done    (done),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .a_rdata (a_rdata),
      .b_rdata (b_rdata),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   logic [31:0] a_mem [N];
   logic [31:0] b_mem [N];
   logic [31:0] exp_mem [N];
   logic [31:0] res_mem [N];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read RAM models: data valid one cycle after rd_en
   always @(posedge clk) begin
      if (rd_en) begin
         a_rdata <= a_mem[rd_addr];
         b_rdata <= b_mem[rd_addr];
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   int wr_cnt, done_cnt, busy_cnt, first_wr, last_wr, done_cyc, start_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic clear_mon();
      wr_cnt   = 0;
      done_cnt = 0;
      busy_cnt = 0;
      first_wr = -1;
      last_wr  = -1;
      done_cyc = -1;
   endtask

   // Write / done / busy monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (wr_en) begin
         if (wr_cnt < N) begin
            check("wr_order", 32'(wr_addr), wr_cnt);
            res_mem[wr_cnt] = wr_data;
         end
         if (wr_cnt == 0) first_wr = cyc;
         last_wr = cyc;
         wr_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [17];

   // Called at a negedge; start is sampled at the following edge (T0)
   task automatic launch(input logic [1:0] op_v);
      start     = 1'b1;
      op        = op_v;
      start_cyc = cyc;
      clear_mon();
      for (int k = 0; k < N; k++) res_mem[k] = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0;
   endtask

   // poke: stray starts at T0+5, T0+100 and in the done cycle, op flip at T0+50
   task automatic finish_run(input bit poke, input string name);
      bit seen;
      int rel;
      seen = 1'b0;
      for (int i = 0; i < N + 20 && !seen; i++) begin
         rel = cyc - start_cyc;
         if (poke) begin
            start = (rel == 5 || rel == 100);
            if (rel == 50) op = 2'b10;
         end
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         check({name, "_done_timeout"}, 32'd0, 32'd1);
      end else begin
         if (poke) start = 1'b1;
         @(negedge clk);
         check({name, "_busy_after_done"}, 32'(busy), 32'd0);
         check({name, "_done_after_done"}, 32'(done), 32'd0);
         check({name, "_done_count"}, done_cnt, 32'd1);
         check({name, "_wr_count"}, wr_cnt, N);
         check({name, "_first_wr_cyc"}, first_wr - start_cyc, 32'd3);
         check({name, "_last_wr_cyc"}, last_wr - start_cyc, N + 2);
         check({name, "_done_cyc"}, done_cyc - start_cyc, N + 3);
         check({name, "_busy_len"}, busy_cnt, N + 3);
         check({name, "_rd_addr_hold"}, 32'(rd_addr), N - 1);
         check({name, "_wr_addr_hold"}, 32'(wr_addr), N - 1);
         for (int k = 0; k < N; k++) begin
            check($sformatf("%s_data[%0d]", name, k), res_mem[k], exp_mem[k]);
         end
      end
   endtask

   task automatic fill_modadd_ramp();
      for (int k = 0; k < N; k++) begin
         a_mem[k]   = k;
         b_mem[k]   = 32'd8380416;
         exp_mem[k] = (k == 0) ? 32'd8380416 : 32'(k - 1);
      end
   endtask

   initial begin
      int sel[$];
      bit hit;

      tbl[0]  = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
      tbl[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFE};
      tbl[2]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      tbl[3]  = '{2'b00, 32'd1,         32'd2,         32'd3};
      tbl[4]  = '{2'b01, 32'd0,         32'd0,         32'd0};
      tbl[5]  = '{2'b01, 32'd1,         32'd8380416,   32'd0};
      tbl[6]  = '{2'b01, 32'd8380416,   32'd8380416,   32'd8380415};
      tbl[7]  = '{2'b01, 32'd5,         32'd7,         32'd12};
      tbl[8]  = '{2'b01, 32'd4190208,   32'd4190209,   32'd0};
      tbl[9]  = '{2'b01, 32'd4190208,   32'd4190208,   32'd8380416};
      tbl[10] = '{2'b10, 32'd0,         32'd1,         32'd8380416};
      tbl[11] = '{2'b10, 32'd5,         32'd5,         32'd0};
      tbl[12] = '{2'b10, 32'd0,         32'd8380416,   32'd1};
      tbl[13] = '{2'b10, 32'd8380416,   32'd0,         32'd8380416};
      tbl[14] = '{2'b10, 32'd3,         32'd10,        32'd8380410};
      tbl[15] = '{2'b11, 32'd10,        32'd3,         32'd7};
      tbl[16] = '{2'b11, 32'd0,         32'd1,         32'd8380416};

      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      clear_mon();
      repeat (3) @(negedge clk);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_rd_en",   32'(rd_en),   32'd0);
      check("rst_wr_en",   32'(wr_en),   32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", wr_data,      32'd0);
      rst = 1'b0;
      @(negedge clk);

      // One full run per op code, RAM entries cycling through that op's vectors
      for (int o = 0; o < 4; o++) begin
         sel.delete();
         for (int i = 0; i < 17; i++) if (tbl[i].op == 2'(o)) sel.push_back(i);
         for (int k = 0; k < N; k++) begin
            a_mem[k]   = tbl[sel[k % sel.size()]].a;
            b_mem[k]   = tbl[sel[k % sel.size()]].b;
            exp_mem[k] = tbl[sel[k % sel.size()]].exp;
         end
         launch(2'(o));
         finish_run(1'b0, $sformatf("tbl_op%0d", o));
      end

      // Stray starts, op change mid-run, start in done cycle ignored
      fill_modadd_ramp();
      launch(2'b01);
      finish_run(1'b1, "handshake");

      // start still held high in the cycle after done: accepted as a new run
      for (int k = 0; k < N; k++) begin
         a_mem[k]   = 32'd0;
         b_mem[k]   = 32'd1;
         exp_mem[k] = 32'd8380416;
      end
      launch(2'b10);
      finish_run(1'b0, "back2back");

      // Reset at the 100th write aborts cleanly
      fill_modadd_ramp();
      launch(2'b01);
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         if (wr_en && wr_addr == 8'd99) hit = 1'b1;
         else @(negedge clk);
      end
      check("abort_reach_wr99", 32'(hit), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_wr_en", 32'(wr_en), 32'd0);
      check("abort_rd_en", 32'(rd_en), 32'd0);
      check("abort_busy",  32'(busy),  32'd0);
      check("abort_done",  32'(done),  32'd0);
      clear_mon();
      repeat (10) @(negedge clk);
      check("abort_no_done",   done_cnt, 32'd0);
      check("abort_no_writes", wr_cnt,   32'd0);
      check("abort_no_busy",   busy_cnt, 32'd0);

      launch(2'b01);
      finish_run(1'b0, "after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/poly_addsub_ctrl.md
Name: poly_addsub_ctrl

Overview:
Sequential controller that streams one coefficient pair per cycle from two polynomial RAMs (A, B), computes a raw add, modular add or modular sub mod Q, and writes the result to a third RAM. It replaces the fully parallel 256-lane adder wherever area matters (t0/t1 and w updates in Dilithium sign/verify). It owns address generation, the pipeline and the start/busy/done handshake.

Parameters:
N, 256, coefficients per polynomial
ADDR_W, 8, RAM address width (2^ADDR_W >= N)
Q, 8380417, modulus for reduced ops

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request; accepted only in IDLE
op  in  2  00 raw add (32-bit wrap), 01 add mod Q, 10 sub mod Q, 11 reserved (treated as 10)
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse after the last write
rd_en  out  1  read strobe to RAMs A and B
rd_addr  out  ADDR_W  shared read address for A and B
a_rdata  in  32  RAM A data, valid exactly 1 cycle after rd_en
b_rdata  in  32  RAM B data, valid exactly 1 cycle after rd_en
wr_en  out  1  write strobe to result RAM
wr_addr  out  ADDR_W  result address
wr_data  out  32  result coefficient

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; pipeline valid bits cleared. Reset mid-run aborts immediately. No further writes occur and done does not pulse.
- op is latched when start is accepted. Changes to op during a run are ignored.
- FSM:
  - IDLE: start=1 moves to RUN, latches op and clears the read counter. start while not in IDLE is ignored (no queueing).
  - RUN: rd_en=1 and rd_addr=counter each cycle. The counter increments each cycle. After issuing address N-1, the FSM moves to DRAIN.
  - DRAIN: rd_en=0. Waits until the write for index N-1 has been issued, then moves to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Pipeline:
  - Stage 0: read issued at cycle c.
  - Stage 1: a_rdata/b_rdata valid at c+1. The result is computed combinationally and registered.
  - Stage 2: wr_en=1, wr_addr=index, wr_data=result during cycle c+2.
  - Index k is written exactly 2 cycles after it is read. Writes are in ascending address order with no gaps.
- Timing, with start accepted at edge T0:
  - First rd_en at cycle T0+1.
  - Last read at T0+N.
  - Writes at T0+3 .. T0+N+2.
  - done at T0+N+3.
  - Total busy length is N+3 cycles; for N=256 this is 259 cycles.
- Arithmetic (inputs for reduced ops are assumed canonical, 0 <= x < Q):
  - op 00: r = a + b mod 2^32, signed two's-complement wrap, no reduction.
  - op 01: s = a + b in 33 bits; r = (s >= Q) ? s - Q : s.
  - op 10: d = a - b in 33-bit signed; r = (d < 0) ? d + Q : d.
  - Results for reduced ops are always in [0, Q-1].
- Counters are sized ADDR_W+1 so the N-1 to N transition is detected without wrap-around aliasing.
- rd_addr and wr_addr hold their last value when their strobe is low.
- A start asserted in the same cycle as done is ignored, because the FSM is not yet in IDLE. A new start is accepted from the following cycle.
- Back-to-back runs: the earliest next start is the cycle after done. Its first read occurs 2 cycles after done.

Test Plan:
- Mod add, A[k]=k, B[k]=Q-1, start with op=01 -> wr_data[0]=Q-1 (8380416); wr_data[k]=k-1 for k>=1; 256 writes at T0+3..T0+258; done pulses once at T0+259.
- Mod sub, A[k]=0, B[k]=1, op=10 -> every wr_data=8380416; A=B=5 gives 0.
- Raw add, A[k]=32'h7FFFFFFF, B[k]=1, op=00 -> wr_data=32'h80000000 (wrap); A=-3, B=1 gives 32'hFFFFFFFE.
- Handshake: start pulses at T0+5, at T0+100, and in the done cycle -> all three ignored; exactly 256 writes; busy drops after done; start one cycle later is accepted.
- Reset mid-run: assert rst at the 100th write -> next cycle wr_en=0, rd_en=0, busy=0; no done pulse; a fresh start then runs a full, correct 259-cycle sequence.
- op change mid-run: start with op=01, then drive op=10 during RUN -> all 256 results match the mod-add reference model.
